// File: rtl/rc5_pkg.sv
// ----------------------------------------------------------------------------
// rc5_pkg
// Shared types and constants for the RC5-32 engine scheduler slice.
//   rc5_mode_e     : job direction (encrypt / decrypt)
//   sched_state_e  : scheduler FSM states
//   RC5_W          : RC5 word width
//   RC5_BLK_W      : block width (A|B)
//   RC5_DEF_ROUNDS : default round count
//   wrap_inc()     : increment modulo n, used for the round-robin pointer
// ----------------------------------------------------------------------------
package rc5_pkg;

  localparam int RC5_W          = 32;
  localparam int RC5_BLK_W      = 2 * RC5_W;
  localparam int RC5_DEF_ROUNDS = 12;

  typedef enum logic {
    RC5_ENC = 1'b0,
    RC5_DEC = 1'b1
  } rc5_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_RESP  = 3'd4
  } sched_state_e;

  // Returns (v + 1) mod n for 0 <= v < n.
  function automatic int wrap_inc(input int v, input int n);
    int r;
    if (v + 1 >= n) begin
      r = 0;
    end else begin
      r = v + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rc5_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rc5_rr_arbiter
// Combinational round-robin arbiter: picks the first requesting client at or
// after rr_ptr (wrapping modulo N_REQ), only while the key table is valid.
// Ports:
//   req_valid [N_REQ]        per-client request
//   key_valid                gate: no grant while the key table is not ready
//   rr_ptr    [clog2(N_REQ)] highest-priority client this cycle
//   grant     [N_REQ]        one-hot grant, or zero
//   grant_id  [clog2(N_REQ)] index of the granted client (0 when none)
//   grant_any                some client is granted
// ----------------------------------------------------------------------------
module rc5_rr_arbiter
  import rc5_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req_valid,
  input  logic                     key_valid,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     grant_any
);

  localparam int ID_W = $clog2(N_REQ);

  // Scan priorities starting from rr_ptr; the loop index is compared rather
  // than used as a dynamic bit index so every select stays constant.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    if (key_valid) begin
      for (int off = 0; off < N_REQ; off++) begin
        for (int i = 0; i < N_REQ; i++) begin
          if (!grant_any && req_valid[i] &&
              (i == ((int'(rr_ptr) + off) % N_REQ))) begin
            grant[i]  = 1'b1;
            grant_id  = ID_W'(i);
            grant_any = 1'b1;
          end else begin
            grant_any = grant_any;
          end
        end
      end
    end else begin
      grant     = '0;
      grant_id  = '0;
      grant_any = 1'b0;
    end
  end

endmodule

// File: rtl/rc5_engine_scheduler.sv
// ----------------------------------------------------------------------------
// rc5_engine_scheduler
// Sequences a shared one-round-per-cycle RC5-32 engine for N_REQ clients.
// One job at a time: IDLE -> LOAD -> ROUND x NUM_ROUNDS -> [FINAL] -> RESP.
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   req_valid/ready/mode/data  per-client job request (ready is one-hot/zero)
//   key_valid                key table ready (only looked at in IDLE)
//   key_lock                 high while a job is in flight
//   eng_din/load/step/fin/mode/round  engine control strobes (registered)
//   eng_dout                 engine state, result source
//   rsp_valid/ready/id/data  shared response channel
// Optional build macro RC5_SCHED_PERF_EN adds perf_jobs[15:0] (response
// handshakes) and perf_busy[31:0] (cycles with key_lock=1), both saturating.
// ----------------------------------------------------------------------------
module rc5_engine_scheduler
  import rc5_pkg::*;
#(
  parameter int NUM_ROUNDS = RC5_DEF_ROUNDS,
  parameter int N_REQ      = 2,
  parameter int RND_W      = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ-1:0]             req_mode,
  input  logic [N_REQ*RC5_BLK_W-1:0]   req_data,
  input  logic                         key_valid,
  output logic                         key_lock,
  output logic [RC5_BLK_W-1:0]         eng_din,
  output logic                         eng_load,
  output logic                         eng_step,
  output logic                         eng_fin,
  output logic                         eng_mode,
  output logic [RND_W-1:0]             eng_round,
  input  logic [RC5_BLK_W-1:0]         eng_dout,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(N_REQ)-1:0]     rsp_id,
  output logic [RC5_BLK_W-1:0]         rsp_data
`ifdef RC5_SCHED_PERF_EN
  ,
  output logic [15:0]                  perf_jobs,
  output logic [31:0]                  perf_busy
`endif
);

  localparam int ID_W = $clog2(N_REQ);
  localparam logic [RND_W-1:0] RND_FIRST = RND_W'(1);
  localparam logic [RND_W-1:0] RND_LAST  = RND_W'(NUM_ROUNDS);

  sched_state_e          state_r;
  logic [ID_W-1:0]       rr_ptr_r;
  logic [RND_W-1:0]      cnt_r;
  rc5_mode_e             mode_r;
  logic [ID_W-1:0]       id_r;

  logic [N_REQ-1:0]      grant_s;
  logic [ID_W-1:0]       grant_id_s;
  logic                  grant_any_s;
  logic                  accept_s;
  logic [RC5_BLK_W-1:0]  sel_data_s;
  rc5_mode_e             sel_mode_s;
  logic [ID_W-1:0]       rr_next_s;
  logic                  last_round_s;
  logic [RND_W-1:0]      cnt_next_s;

  rc5_rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req_valid(req_valid),
    .key_valid(key_valid),
    .rr_ptr   (rr_ptr_r),
    .grant    (grant_s),
    .grant_id (grant_id_s),
    .grant_any(grant_any_s)
  );

  // Grant is only offered in IDLE and never while reset is held.
  always_comb begin
    req_ready = '0;
    accept_s  = 1'b0;
    if (rst && (state_r == ST_IDLE)) begin
      req_ready = grant_s;
      accept_s  = grant_any_s;
    end else begin
      req_ready = '0;
      accept_s  = 1'b0;
    end
  end

  // Mux the granted client's block and mode.
  always_comb begin
    sel_data_s = '0;
    sel_mode_s = RC5_ENC;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_s[i]) begin
        sel_data_s = req_data[i*RC5_BLK_W +: RC5_BLK_W];
        sel_mode_s = rc5_mode_e'(req_mode[i]);
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Round counter stepping: up for encrypt, down for decrypt.
  always_comb begin
    rr_next_s = ID_W'(wrap_inc(int'(grant_id_s), N_REQ));
    if (mode_r == RC5_DEC) begin
      last_round_s = (cnt_r == RND_FIRST);
      cnt_next_s   = cnt_r - RND_W'(1);
    end else begin
      last_round_s = (cnt_r == RND_LAST);
      cnt_next_s   = cnt_r + RND_W'(1);
    end
  end

  // The result is exposed only while a response is being offered.
  always_comb begin
    if (rsp_valid) begin
      rsp_data = eng_dout;
    end else begin
      rsp_data = '0;
    end
  end

  // Scheduler FSM; all strobes are registered alongside the state so they
  // line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      rr_ptr_r  <= '0;
      cnt_r     <= '0;
      mode_r    <= RC5_ENC;
      id_r      <= '0;
      key_lock  <= 1'b0;
      eng_din   <= '0;
      eng_load  <= 1'b0;
      eng_step  <= 1'b0;
      eng_fin   <= 1'b0;
      eng_mode  <= 1'b0;
      eng_round <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r  <= ST_LOAD;
            mode_r   <= sel_mode_s;
            id_r     <= grant_id_s;
            rr_ptr_r <= rr_next_s;
            cnt_r    <= (sel_mode_s == RC5_DEC) ? RND_LAST : RND_FIRST;
            key_lock <= 1'b1;
            eng_load <= 1'b1;
            eng_din  <= sel_data_s;
            eng_mode <= sel_mode_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          state_r   <= ST_ROUND;
          eng_load  <= 1'b0;
          eng_din   <= '0;
          eng_step  <= 1'b1;
          eng_round <= cnt_r;
        end
        ST_ROUND: begin
          if (last_round_s) begin
            eng_step  <= 1'b0;
            eng_round <= '0;
            if (mode_r == RC5_DEC) begin
              state_r <= ST_FINAL;
              eng_fin <= 1'b1;
            end else begin
              state_r   <= ST_RESP;
              eng_mode  <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_id    <= id_r;
            end
          end else begin
            cnt_r     <= cnt_next_s;
            eng_round <= cnt_next_s;
          end
        end
        ST_FINAL: begin
          state_r   <= ST_RESP;
          eng_fin   <= 1'b0;
          eng_mode  <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_id    <= id_r;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_r   <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            key_lock  <= 1'b0;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          key_lock  <= 1'b0;
          eng_din   <= '0;
          eng_load  <= 1'b0;
          eng_step  <= 1'b0;
          eng_fin   <= 1'b0;
          eng_mode  <= 1'b0;
          eng_round <= '0;
          rsp_valid <= 1'b0;
          rsp_id    <= '0;
        end
      endcase
    end
  end

`ifdef RC5_SCHED_PERF_EN
  // Saturating activity counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_jobs <= '0;
      perf_busy <= '0;
    end else begin
      if (rsp_valid && rsp_ready && (perf_jobs != 16'hFFFF)) begin
        perf_jobs <= perf_jobs + 16'd1;
      end else begin
        perf_jobs <= perf_jobs;
      end
      if (key_lock && (perf_busy != 32'hFFFF_FFFF)) begin
        perf_busy <= perf_busy + 32'd1;
      end else begin
        perf_busy <= perf_busy;
      end
    end
  end
`endif

endmodule
